// File: rtl/onex4_32bit_demux_buf_pkg.sv
// Shared constants and helpers for the 1-to-4 word distributor.
// Optional drain counters elsewhere are enabled by the DEMUX_CNT_EN macro.
package cpu_defs;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 16;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_OUT-1:0] sel_decode(input sel_t sel);
    logic [NUM_OUT-1:0] hot;
    hot = '0;
    hot[sel] = 1'b1;
    return hot;
  endfunction
endpackage

// File: rtl/onex4_32bit_demux_buf_if.sv
// Producer/consumer bundle for onex4_32bit_demux_buf.
// DEMUX_CNT_EN adds the per-slot drain counters Out_cnt0..Out_cnt3.
interface onex4_32bit_demux_buf_if #(parameter int WIDTH = cpu_defs::WORD_W);
  import cpu_defs::*;

  // valid/ready: a word moves on a rising edge where valid and ready are both
  // high; the sender holds its payload stable until that edge.
  logic [WIDTH-1:0]   In;
  logic               In_valid;
  logic               In_ready;
  sel_t               Sel;
  logic [WIDTH-1:0]   Out0;
  logic [WIDTH-1:0]   Out1;
  logic [WIDTH-1:0]   Out2;
  logic [WIDTH-1:0]   Out3;
  logic [NUM_OUT-1:0] Out_valid;
  logic [NUM_OUT-1:0] Out_ready;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]   Out_cnt0;
  logic [CNT_W-1:0]   Out_cnt1;
  logic [CNT_W-1:0]   Out_cnt2;
  logic [CNT_W-1:0]   Out_cnt3;
`endif

  modport slave (
    input  In, In_valid, Sel, Out_ready,
    output In_ready, Out0, Out1, Out2, Out3, Out_valid
`ifdef DEMUX_CNT_EN
    , output Out_cnt0, Out_cnt1, Out_cnt2, Out_cnt3
`endif
  );

  modport master (
    output In, In_valid, Sel, Out_ready,
    input  In_ready, Out0, Out1, Out2, Out3, Out_valid
`ifdef DEMUX_CNT_EN
    , input Out_cnt0, Out_cnt1, Out_cnt2, Out_cnt3
`endif
  );
endinterface

// File: rtl/onex4_32bit_demux_buf_one_slot_buf.sv
// Single-entry output buffer for one destination; a write on the same edge
// as a drain wins, so the slot stays full. DEMUX_CNT_EN adds a drain counter.
module one_slot_buf
  import cpu_defs::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);
  logic drain;
  assign drain = valid & rd_ready;

  // Data is left in place after a drain; only valid tells the consumer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif
endmodule

// File: rtl/onex4_32bit_demux_buf.sv
// 1-to-4 distributor: steers each accepted word by Sel into one of four
// single-entry buffers. DEMUX_CNT_EN enables per-slot drain counters.
module onex4_32bit_demux_buf
  import cpu_defs::*;
#(
  parameter int WIDTH = WORD_W
) (
  input logic                      clk,
  input logic                      reset_n,
  onex4_32bit_demux_buf_if.slave   bus
);
  logic [NUM_OUT-1:0] sel_hot;
  logic [NUM_OUT-1:0] wr_en;
  logic [NUM_OUT-1:0] valid;
  logic [WIDTH-1:0]   data [NUM_OUT];
  logic               in_ready;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]   cnt [NUM_OUT];
`endif

  // Ready depends only on the addressed slot, never on In_valid.
  assign in_ready = reset_n & (~valid[bus.Sel] | bus.Out_ready[bus.Sel]);
  assign sel_hot  = sel_decode(bus.Sel);
  assign wr_en    = {NUM_OUT{bus.In_valid & in_ready}} & sel_hot;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    one_slot_buf #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en[i]),
      .wr_data  (bus.In),
      .rd_ready (bus.Out_ready[i]),
      .data     (data[i]),
      .valid    (valid[i])
`ifdef DEMUX_CNT_EN
      , .cnt    (cnt[i])
`endif
    );
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = valid;
  assign bus.Out0      = data[0];
  assign bus.Out1      = data[1];
  assign bus.Out2      = data[2];
  assign bus.Out3      = data[3];
`ifdef DEMUX_CNT_EN
  assign bus.Out_cnt0  = cnt[0];
  assign bus.Out_cnt1  = cnt[1];
  assign bus.Out_cnt2  = cnt[2];
  assign bus.Out_cnt3  = cnt[3];
`endif
endmodule
